// File: rtl/coletor_pkg.sv
// Shared constants and state encoding for the result collector.
package coletor_pkg;

  localparam int N_ELEM     = 25;
  localparam int W_RES      = 9;
  localparam int N_PALAVRAS = 9;

  localparam int VALID_BIT = 30;
  localparam int CAMPO0    = 0;
  localparam int CAMPO1    = 9;
  localparam int CAMPO2    = 18;

  typedef enum logic [1:0] {
    ESPERA_VALID = 2'd0,
    ACK          = 2'd1,
    COMPLETO     = 2'd2
  } estado_t;

endpackage

// File: rtl/coletor_resultado_if.sv
// Producer/consumer bus of the result collector; erro exists only with COLETOR_CHECK_EN.
interface coletor_resultado_if #(
  parameter int W_RES = coletor_pkg::W_RES
);
  logic [31:0]      dado_in;
  logic             ack_out;
  logic             libera;
  logic [4:0]       rd_addr;
  logic [W_RES-1:0] rd_data;
  logic             pronta;
  logic [3:0]       palavras;
`ifdef COLETOR_CHECK_EN
  logic             erro;
`endif

  modport master (
    output dado_in, libera, rd_addr,
    input  ack_out, rd_data, pronta, palavras
`ifdef COLETOR_CHECK_EN
    , input erro
`endif
  );

  modport slave (
    input  dado_in, libera, rd_addr,
    output ack_out, rd_data, pronta, palavras
`ifdef COLETOR_CHECK_EN
    , output erro
`endif
  );
endinterface

// File: rtl/coletor_resultado_buffer.sv
// Result matrix storage: three write ports, one registered read port.
// Contents survive reset; only the read register is cleared.
module buffer_resultado #(
  parameter int N_ELEM = 25,
  parameter int W_RES  = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we0_i,
  input  logic             we1_i,
  input  logic             we2_i,
  input  logic [4:0]       waddr0_i,
  input  logic [4:0]       waddr1_i,
  input  logic [4:0]       waddr2_i,
  input  logic [W_RES-1:0] wdata0_i,
  input  logic [W_RES-1:0] wdata1_i,
  input  logic [W_RES-1:0] wdata2_i,
  input  logic [4:0]       rd_addr_i,
  output logic [W_RES-1:0] rd_data_o
);
  localparam logic [4:0] ULTIMO = 5'(N_ELEM - 1);

  logic [W_RES-1:0] mem_q [N_ELEM];
  logic [W_RES-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
    if (we2_i) mem_q[waddr2_i] <= wdata2_i;
  end

  // Out-of-range indices read as zero rather than aliasing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    rd_data_q <= '0;
    else if (rd_addr_i <= ULTIMO) rd_data_q <= mem_q[rd_addr_i];
    else                          rd_data_q <= '0;
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/coletor_resultado.sv
// Collects 9 four-phase handshaked words into a 25-element result matrix.
// COLETOR_CHECK_EN adds the sticky protocol-check flag erro.
module coletor_resultado #(
  parameter int N_ELEM = coletor_pkg::N_ELEM,
  parameter int W_RES  = coletor_pkg::W_RES
) (
  input logic                clk,
  input logic                reset,
  coletor_resultado_if.slave bus
);
  import coletor_pkg::*;

  estado_t    estado_q, estado_d;
  logic       ack_q, ack_d;
  logic       pronta_q, pronta_d;
  logic [3:0] palavras_q, palavras_d;
  logic       valid, captura, ultima;
  logic [4:0] base;
  logic       unused_bits;

  assign valid       = bus.dado_in[VALID_BIT];
  assign ultima      = (palavras_q == 4'(N_PALAVRAS - 1));
  assign captura     = (estado_q == ESPERA_VALID) && valid;
  assign base        = {palavras_q, 1'b0} + {1'b0, palavras_q};
  assign unused_bits = ^{bus.dado_in[31], bus.dado_in[29:27]};

  always_comb begin
    estado_d   = estado_q;
    ack_d      = ack_q;
    pronta_d   = pronta_q;
    palavras_d = palavras_q;
    case (estado_q)
      ESPERA_VALID: begin
        if (valid) begin
          estado_d = ACK;
          ack_d    = 1'b1;
        end
      end
      ACK: begin
        if (!valid) begin
          ack_d      = 1'b0;
          palavras_d = palavras_q + 4'd1;
          if (ultima) begin
            estado_d = COMPLETO;
            pronta_d = 1'b1;
          end else begin
            estado_d = ESPERA_VALID;
          end
        end
      end
      COMPLETO: begin
        if (bus.libera) begin
          estado_d   = ESPERA_VALID;
          pronta_d   = 1'b0;
          palavras_d = '0;
        end
      end
      default: estado_d = ESPERA_VALID;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= ESPERA_VALID;
      ack_q      <= 1'b0;
      pronta_q   <= 1'b0;
      palavras_q <= '0;
    end else begin
      estado_q   <= estado_d;
      ack_q      <= ack_d;
      pronta_q   <= pronta_d;
      palavras_q <= palavras_d;
    end
  end

  assign bus.ack_out  = ack_q;
  assign bus.pronta   = pronta_q;
  assign bus.palavras = palavras_q;

`ifdef COLETOR_CHECK_EN
  logic erro_q, erro_d;

  always_comb begin
    erro_d = erro_q;
    if (estado_q == COMPLETO && bus.libera)
      erro_d = 1'b0;
    else if (captura && ((|bus.dado_in[29:27]) || (ultima && (|bus.dado_in[26:9]))))
      erro_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) erro_q <= 1'b0;
    else       erro_q <= erro_d;
  end

  assign bus.erro = erro_q;
`endif

  // The last word carries a single element, so only port 0 writes then.
  buffer_resultado #(.N_ELEM(N_ELEM), .W_RES(W_RES)) u_buffer (
    .clk_i     (clk),
    .rst_i     (reset),
    .we0_i     (captura),
    .we1_i     (captura && !ultima),
    .we2_i     (captura && !ultima),
    .waddr0_i  (base),
    .waddr1_i  (base + 5'd1),
    .waddr2_i  (base + 5'd2),
    .wdata0_i  (bus.dado_in[CAMPO0 +: W_RES]),
    .wdata1_i  (bus.dado_in[CAMPO1 +: W_RES]),
    .wdata2_i  (bus.dado_in[CAMPO2 +: W_RES]),
    .rd_addr_i (bus.rd_addr),
    .rd_data_o (bus.rd_data)
  );
endmodule

// File: tb/tb_coletor_resultado.sv
// Directed self-checking bench for coletor_resultado (erro checks only with COLETOR_CHECK_EN).
module tb_coletor_resultado;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] VLD = 32'h4000_0000;

  coletor_resultado_if #(.W_RES(9)) bus ();

  coletor_resultado #(.N_ELEM(25), .W_RES(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack3(input int a, input int b, input int c);
    return 32'(a) | (32'(b) << 9) | (32'(c) << 18);
  endfunction

  task automatic send_word(input string tag, input logic [31:0] w);
    bus.dado_in = w | VLD;
    tick();
    chk({tag, "_ack_rise"}, 32'(bus.ack_out), 1);
    bus.dado_in = w & ~VLD;
    tick();
    chk({tag, "_ack_fall"}, 32'(bus.ack_out), 0);
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    tick();
    chk(tag, 32'(bus.rd_data), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.dado_in = '0;
    bus.libera  = 1'b0;
    bus.rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_ack", 32'(bus.ack_out), 0);
    chk("rst_pronta", 32'(bus.pronta), 0);
    chk("rst_palavras", 32'(bus.palavras), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
`ifdef COLETOR_CHECK_EN
    chk("rst_erro", 32'(bus.erro), 0);
`endif

    // Full matrix: elements 0..24 hold 1..25
    for (int i = 0; i < 8; i++) begin
      send_word("fill", pack3(3*i+1, 3*i+2, 3*i+3));
      chk("fill_palavras", 32'(bus.palavras), 32'(i+1));
      chk("fill_pronta_low", 32'(bus.pronta), 0);
    end
    send_word("fill_w8", 32'd25);
    chk("fill_pronta", 32'(bus.pronta), 1);
    chk("fill_palavras9", 32'(bus.palavras), 9);
    for (int a = 0; a < 25; a++) read_chk("fill_read", 5'(a), 32'(a+1));
    read_chk("read_oob31", 5'd31, 0);

    // Backpressure in COMPLETO, then libera with valid already high
    bus.dado_in = 32'h4000_01FF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ack", 32'(bus.ack_out), 0);
      chk("bp_pronta", 32'(bus.pronta), 1);
    end
    read_chk("bp_buf_unchanged", 5'd0, 1);
    bus.libera = 1'b1;
    tick();
    bus.libera = 1'b0;
    chk("lib_pronta", 32'(bus.pronta), 0);
    chk("lib_palavras", 32'(bus.palavras), 0);
    chk("lib_no_ack_yet", 32'(bus.ack_out), 0);
    tick();
    chk("lib_ack_next", 32'(bus.ack_out), 1);
    bus.dado_in = '0;
    tick();
    chk("lib_ack_fall", 32'(bus.ack_out), 0);
    chk("lib_palavras1", 32'(bus.palavras), 1);
    read_chk("lib_idx0", 5'd0, 32'h1FF);
    read_chk("lib_idx1", 5'd1, 0);

    // Reset keeps buffer; long valid gives a single capture
    reset = 1'b1;
    #2;
    chk("rst2_palavras", 32'(bus.palavras), 0);
    reset = 1'b0;
    read_chk("rst2_buf_kept", 5'd5, 6);
    bus.dado_in = pack3(10, 20, 30) | VLD;
    tick();
    chk("hold_ack", 32'(bus.ack_out), 1);
    chk("hold_palavras0", 32'(bus.palavras), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hold_ack_stays", 32'(bus.ack_out), 1);
      chk("hold_palavras_stays", 32'(bus.palavras), 0);
    end
    bus.dado_in = '0;
    tick();
    chk("hold_ack_fall", 32'(bus.ack_out), 0);
    chk("hold_palavras1", 32'(bus.palavras), 1);
    send_word("w1", pack3(40, 41, 42));
    chk("w1_palavras", 32'(bus.palavras), 2);
    read_chk("hold_idx0", 5'd0, 10);
    read_chk("hold_idx2", 5'd2, 30);
    read_chk("w1_idx3", 5'd3, 40);
    read_chk("w1_idx5", 5'd5, 42);

    // libera outside COMPLETO is ignored
    bus.libera = 1'b1;
    tick();
    bus.libera = 1'b0;
    chk("lib_ignored_palavras", 32'(bus.palavras), 2);
    chk("lib_ignored_pronta", 32'(bus.pronta), 0);
    send_word("w2", pack3(50, 51, 52));
    send_word("w3", pack3(60, 61, 62));
    chk("w3_palavras", 32'(bus.palavras), 4);
    read_chk("w2_idx6", 5'd6, 50);
    read_chk("w3_idx9", 5'd9, 60);

    // Reset mid-matrix while ack is high
    bus.dado_in = pack3(70, 71, 72) | VLD;
    tick();
    chk("mid_ack", 32'(bus.ack_out), 1);
    reset = 1'b1;
    #2;
    chk("mid_rst_ack", 32'(bus.ack_out), 0);
    chk("mid_rst_palavras", 32'(bus.palavras), 0);
    chk("mid_rst_pronta", 32'(bus.pronta), 0);
    bus.dado_in = '0;
    reset = 1'b0;
    tick();
    send_word("after_rst", pack3(7, 8, 9));
    chk("after_rst_palavras", 32'(bus.palavras), 1);
    read_chk("after_rst_idx0", 5'd0, 7);
    read_chk("after_rst_idx3", 5'd3, 40);
    read_chk("mid_idx12", 5'd12, 70);

    // Last word with stray bits in the unused fields
    for (int i = 1; i < 8; i++) send_word("tail", pack3(3*i, 3*i+1, 3*i+2));
`ifdef COLETOR_CHECK_EN
    chk("erro_before", 32'(bus.erro), 0);
`endif
    send_word("w8_bad", 32'h0000_0201);
    chk("w8_pronta", 32'(bus.pronta), 1);
    read_chk("w8_idx24", 5'd24, 1);
    read_chk("w8_idx23", 5'd23, 23);
`ifdef COLETOR_CHECK_EN
    chk("erro_set", 32'(bus.erro), 1);
    repeat (3) tick();
    chk("erro_sticky", 32'(bus.erro), 1);
`endif
    bus.libera = 1'b1;
    tick();
    bus.libera = 1'b0;
    chk("final_pronta", 32'(bus.pronta), 0);
    chk("final_palavras", 32'(bus.palavras), 0);
`ifdef COLETOR_CHECK_EN
    chk("erro_cleared", 32'(bus.erro), 0);
    send_word("rsvd_bits", 32'h0800_0003);
    chk("erro_rsvd", 32'(bus.erro), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
